i2c_master_reader: RTL and testbench

I2C_MASTER_READER -- requirements
Module: i2c_master_reader

---
 rtl/i2c_master_reader.sv | 164 ++++++++++++++++
 tb/tb_i2c_master_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_reader.sv
// I2C random-read master: writes a memory address to the slave, issues a
// repeated START, then reads in_len bytes, ACKing every byte but the last.
module i2c_master_reader #(
    parameter int         CLK_DIV        = 4,
    parameter logic [6:0] SLAVE_ADDR     = 7'h50,
    parameter int         MEM_ADDR_WIDTH = 16
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic                      in_start,
    input  logic [MEM_ADDR_WIDTH-1:0] in_addr,
    input  logic [7:0]                in_len,
    output logic                      out_scl,
    inout  wire                       io_sda,
    output logic                      out_busy,
    output logic [7:0]                out_data,
    output logic                      out_data_valid,
    output logic                      out_done,
    output logic                      out_nack
);
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK_AW, MADDR_HI, ACK_HI, MADDR_LO, ACK_LO,
        RESTART, ADDR_R, ACK_AR, RDATA, MACK, STOP, DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [DIV_W-1:0]          div_q;
    logic [1:0]                qtr_q;
    logic [2:0]                bit_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                remain_q;
    logic [6:0]                shift_q;
    logic                      ack_q;
    logic                      zero_done_q;
    logic                      tick, last_qtr, slot_end, sample, is_byte, is_ack;
    logic                      sda_low, sda_in;
    logic [7:0]                tx_byte;

    assign sda_in   = io_sda;
    assign io_sda   = sda_low ? 1'b0 : 1'bz;
    assign out_busy = (state_q != IDLE);
    assign out_done = (state_q == DONE) || zero_done_q;

    assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
    assign last_qtr = (state_q == START || state_q == STOP) ? (qtr_q == 2'd2) : (qtr_q == 2'd3);
    assign slot_end = tick && last_qtr;
    assign sample   = (qtr_q == 2'd2) && (div_q == '0);
    assign is_byte  = state_q inside {ADDR_W, MADDR_HI, MADDR_LO, ADDR_R, RDATA};
    assign is_ack   = state_q inside {ACK_AW, ACK_HI, ACK_LO, ACK_AR};

    always_comb begin
        tx_byte = {SLAVE_ADDR, 1'b1};
        case (state_q)
            ADDR_W:   tx_byte = {SLAVE_ADDR, 1'b0};
            MADDR_HI: tx_byte = addr_q[MEM_ADDR_WIDTH-1 -: 8];
            MADDR_LO: tx_byte = addr_q[7:0];
            default:  ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (in_start && in_len != 8'd0) state_d = START;
            START:    if (slot_end) state_d = ADDR_W;
            ADDR_W:   if (slot_end && bit_q == 3'd0) state_d = ACK_AW;
            ACK_AW:   if (slot_end) state_d = ack_q ? STOP : MADDR_HI;
            MADDR_HI: if (slot_end && bit_q == 3'd0) state_d = ACK_HI;
            ACK_HI:   if (slot_end) state_d = ack_q ? STOP : MADDR_LO;
            MADDR_LO: if (slot_end && bit_q == 3'd0) state_d = ACK_LO;
            ACK_LO:   if (slot_end) state_d = ack_q ? STOP : RESTART;
            RESTART:  if (slot_end) state_d = ADDR_R;
            ADDR_R:   if (slot_end && bit_q == 3'd0) state_d = ACK_AR;
            ACK_AR:   if (slot_end) state_d = ack_q ? STOP : RDATA;
            RDATA:    if (slot_end && bit_q == 3'd0) state_d = MACK;
            MACK:     if (slot_end) state_d = (remain_q != 8'd0) ? RDATA : STOP;
            STOP:     if (slot_end) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Bus pins decoded from state/quarter; idle and reset leave both lines high.
    // RESTART opens with an SCL-low quarter so the slave can drop its ACK first.
    always_comb begin
        out_scl = 1'b1;
        sda_low = 1'b0;
        case (state_q)
            START: begin
                out_scl = (qtr_q != 2'd2);
                sda_low = (qtr_q != 2'd0);
            end
            ADDR_W, MADDR_HI, MADDR_LO, ADDR_R: begin
                out_scl = qtr_q[1];
                sda_low = ~tx_byte[bit_q];
            end
            ACK_AW, ACK_HI, ACK_LO, ACK_AR, RDATA: out_scl = qtr_q[1];
            MACK: begin
                out_scl = qtr_q[1];
                sda_low = (remain_q != 8'd0);
            end
            RESTART: begin
                out_scl = qtr_q[1] ^ qtr_q[0];
                sda_low = qtr_q[1];
            end
            STOP: begin
                out_scl = (qtr_q != 2'd0);
                sda_low = (qtr_q != 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q        <= IDLE;
            div_q          <= '0;
            qtr_q          <= '0;
            bit_q          <= 3'd7;
            addr_q         <= '0;
            remain_q       <= '0;
            shift_q        <= '0;
            ack_q          <= 1'b0;
            zero_done_q    <= 1'b0;
            out_data       <= '0;
            out_data_valid <= 1'b0;
            out_nack       <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_data_valid <= 1'b0;
            zero_done_q    <= (state_q == IDLE) && in_start && (in_len == 8'd0);
            if (state_q == IDLE) begin
                div_q <= '0;
                qtr_q <= '0;
                bit_q <= 3'd7;
                if (in_start) begin
                    addr_q   <= in_addr;
                    remain_q <= in_len;
                    out_nack <= 1'b0;
                end
            end else if (tick) begin
                div_q <= '0;
                qtr_q <= last_qtr ? 2'd0 : qtr_q + 2'd1;
                // bit index wraps 0 -> 7 at the end of each byte
                if (last_qtr) bit_q <= is_byte ? bit_q - 3'd1 : 3'd7;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (sample && is_ack) ack_q <= sda_in;
            if (sample && state_q == RDATA) begin
                shift_q <= {shift_q[5:0], sda_in};
                if (bit_q == 3'd0) begin
                    out_data       <= {shift_q, sda_in};
                    out_data_valid <= 1'b1;
                    if (remain_q != 8'd0) remain_q <= remain_q - 8'd1;
                end
            end
            if (slot_end && is_ack && ack_q) out_nack <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_master_reader.sv
// Directed bench: behavioural EEPROM-style slave sampled on the falling clock
// edge, with bus/strobe logs checked against hand-derived expectations.
module tb_i2c_master_reader;
    localparam int M_IDLE = 0, M_RX = 1, M_ACK = 2, M_TX = 3, M_MACK = 4;

    logic        in_clk = 1'b0;
    logic        in_rst, in_start;
    logic [15:0] in_addr;
    logic [7:0]  in_len;
    logic        out_scl, out_busy, out_data_valid, out_done, out_nack;
    logic [7:0]  out_data;
    wire         sda_bus;
    logic        slv_drv, slv_en, slv_present;

    pullup (sda_bus);
    assign sda_bus = (slv_drv && slv_en) ? 1'b0 : 1'bz;

    i2c_master_reader dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_addr(in_addr),
        .in_len(in_len), .out_scl(out_scl), .io_sda(sda_bus), .out_busy(out_busy),
        .out_data(out_data), .out_data_valid(out_data_valid), .out_done(out_done),
        .out_nack(out_nack)
    );

    always #5 in_clk = ~in_clk;

    // slave model / bus monitor state (written only by the monitor process)
    int          m_mode, bc, rx_idx;
    logic [7:0]  sh, txb;
    logic [15:0] ptr;
    logic        rd_mode, mack_bit, prev_scl, prev_sda;
    int          n_start, n_stop, n_scl_e, n_sda_e, n_valid, n_done;
    logic [7:0]  rx_log[$], valid_log[$];
    logic        mack_log[$];

    // bench bookkeeping (written only by the main process)
    int n_checks, n_pass, n_fail;
    int s_rx, s_mack, s_val, s_vlog, s_done, s_start, s_stop, s_scl, s_sda;

    function automatic logic [7:0] slave_mem(input logic [15:0] a);
        case (a)
            16'h0012: return 8'hA5;
            16'h00FE: return 8'h11;
            16'h00FF: return 8'h22;
            16'h0100: return 8'h33;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    initial begin
        m_mode = M_IDLE; slv_drv = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
        bc = 0; rx_idx = 0; sh = '0; txb = '0; ptr = '0; rd_mode = 1'b0; mack_bit = 1'b1;
        n_start = 0; n_stop = 0; n_scl_e = 0; n_sda_e = 0; n_valid = 0; n_done = 0;
        forever begin
            @(negedge in_clk);
            if (out_data_valid) begin n_valid++; valid_log.push_back(out_data); end
            if (out_done) n_done++;
            if (out_scl !== prev_scl) n_scl_e++;
            if (sda_bus !== prev_sda) n_sda_e++;
            if (in_rst) begin
                m_mode = M_IDLE; slv_drv = 1'b0;
            end else if (prev_scl && out_scl) begin
                if (prev_sda && !sda_bus) begin
                    n_start++; m_mode = M_RX; bc = 0; rx_idx = 0; slv_drv = 1'b0;
                end else if (!prev_sda && sda_bus) begin
                    n_stop++; m_mode = M_IDLE; slv_drv = 1'b0;
                end
            end else if (!prev_scl && out_scl) begin
                if (m_mode == M_RX) begin sh = {sh[6:0], sda_bus}; bc++; end
                else if (m_mode == M_MACK) mack_bit = sda_bus;
            end else if (prev_scl && !out_scl) begin
                case (m_mode)
                    M_RX: if (bc == 8) begin
                        rx_log.push_back(sh);
                        if (rx_idx == 0) begin
                            if (slv_present && sh[7:1] == 7'h50) begin
                                rd_mode = sh[0]; slv_drv = 1'b1; m_mode = M_ACK;
                            end else m_mode = M_IDLE;
                        end else begin
                            if (rx_idx == 1) ptr[15:8] = sh; else ptr[7:0] = sh;
                            slv_drv = 1'b1; m_mode = M_ACK;
                        end
                        rx_idx++;
                    end
                    M_ACK: begin
                        slv_drv = 1'b0;
                        if (rd_mode) begin
                            txb = slave_mem(ptr); ptr++; slv_drv = !txb[7]; bc = 1; m_mode = M_TX;
                        end else begin
                            m_mode = M_RX; bc = 0;
                        end
                    end
                    M_TX: if (bc < 8) begin
                        slv_drv = !txb[7-bc]; bc++;
                    end else begin
                        slv_drv = 1'b0; m_mode = M_MACK;
                    end
                    M_MACK: begin
                        mack_log.push_back(mack_bit);
                        if (!mack_bit) begin
                            txb = slave_mem(ptr); ptr++; slv_drv = !txb[7]; bc = 1; m_mode = M_TX;
                        end else m_mode = M_IDLE;
                    end
                    default: ;
                endcase
            end
            prev_scl = out_scl;
            prev_sda = sda_bus;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge in_clk);
        #1;
    endtask

    task automatic snap();
        s_rx = rx_log.size(); s_mack = mack_log.size(); s_val = n_valid; s_vlog = valid_log.size();
        s_done = n_done; s_start = n_start; s_stop = n_stop; s_scl = n_scl_e; s_sda = n_sda_e;
    endtask

    task automatic launch(input logic [15:0] a, input logic [7:0] l);
        in_addr = a; in_len = l; in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    // returns on the cycle out_done is high, or after the cycle budget
    task automatic wait_done(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && n_done == s_done; i++) tick();
        check({tag, " done count"}, n_done - s_done, 1);
        check({tag, " done high"}, out_done, 1'b1);
        check({tag, " busy at done"}, out_busy, 1'b1);
    endtask

    function automatic logic [7:0] rx_at(input int i);
        return (rx_log.size() > i) ? rx_log[i] : 8'hEE;
    endfunction

    function automatic logic [7:0] val_at(input int i);
        return (valid_log.size() > i) ? valid_log[i] : 8'hEE;
    endfunction

    function automatic logic mack_at(input int i);
        return (mack_log.size() > i) ? mack_log[i] : 1'bx;
    endfunction

    task automatic check_frame(input string tag, input logic [7:0] hi, input logic [7:0] lo);
        check({tag, " bytes sent"}, rx_log.size() - s_rx, 4);
        check({tag, " addr_w"}, rx_at(s_rx), 8'hA0);
        check({tag, " maddr_hi"}, rx_at(s_rx + 1), hi);
        check({tag, " maddr_lo"}, rx_at(s_rx + 2), lo);
        check({tag, " addr_r"}, rx_at(s_rx + 3), 8'hA1);
        check({tag, " starts"}, n_start - s_start, 2);
        check({tag, " stops"}, n_stop - s_stop, 1);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        in_rst = 1'b1; in_start = 1'b0; in_addr = '0; in_len = '0;
        slv_en = 1'b1; slv_present = 1'b1;
        repeat (3) tick();
        check("rst scl", out_scl, 1'b1);
        check("rst sda", sda_bus, 1'b1);
        check("rst busy", out_busy, 1'b0);
        check("rst data", out_data, 8'h00);
        check("rst valid", out_data_valid, 1'b0);
        check("rst done", out_done, 1'b0);
        check("rst nack", out_nack, 1'b0);
        in_rst = 1'b0;
        repeat (2) tick();

        // single-byte read
        snap();
        launch(16'h0012, 8'd1);
        check("rd1 busy", out_busy, 1'b1);
        wait_done("rd1", 3000);
        check("rd1 nack", out_nack, 1'b0);
        tick();
        check("rd1 busy after", out_busy, 1'b0);
        check("rd1 done pulse", out_done, 1'b0);
        check_frame("rd1", 8'h00, 8'h12);
        check("rd1 valid count", n_valid - s_val, 1);
        check("rd1 data", val_at(s_vlog), 8'hA5);
        check("rd1 data held", out_data, 8'hA5);
        check("rd1 mack count", mack_log.size() - s_mack, 1);
        check("rd1 mack nack", mack_at(s_mack), 1'b1);

        // three-byte read
        repeat (3) tick();
        snap();
        launch(16'h00FE, 8'd3);
        wait_done("rd3", 4000);
        check("rd3 nack", out_nack, 1'b0);
        check_frame("rd3", 8'h00, 8'hFE);
        check("rd3 valid count", n_valid - s_val, 3);
        check("rd3 byte0", val_at(s_vlog), 8'h11);
        check("rd3 byte1", val_at(s_vlog + 1), 8'h22);
        check("rd3 byte2", val_at(s_vlog + 2), 8'h33);
        check("rd3 mack count", mack_log.size() - s_mack, 3);
        check("rd3 mack0", mack_at(s_mack), 1'b0);
        check("rd3 mack1", mack_at(s_mack + 1), 1'b0);
        check("rd3 mack2", mack_at(s_mack + 2), 1'b1);

        // start while busy is ignored
        repeat (3) tick();
        snap();
        launch(16'h0012, 8'd1);
        repeat (100) tick();
        launch(16'h00FE, 8'd3);
        wait_done("busy", 3000);
        repeat (1500) tick();
        check("busy done once", n_done - s_done, 1);
        check("busy valid count", n_valid - s_val, 1);
        check("busy data", val_at(s_vlog), 8'hA5);
        check("busy idle", out_busy, 1'b0);

        // missing slave
        slv_present = 1'b0;
        snap();
        launch(16'h0012, 8'd1);
        wait_done("noslv", 3000);
        check("noslv nack", out_nack, 1'b1);
        repeat (5) tick();
        check("noslv nack held", out_nack, 1'b1);
        check("noslv valid count", n_valid - s_val, 0);
        check("noslv bytes sent", rx_log.size() - s_rx, 1);
        check("noslv addr_w", rx_at(s_rx), 8'hA0);
        check("noslv starts", n_start - s_start, 1);
        check("noslv stops", n_stop - s_stop, 1);
        slv_present = 1'b1;

        // zero length
        snap();
        launch(16'h0012, 8'd0);
        check("len0 done", out_done, 1'b1);
        check("len0 nack", out_nack, 1'b0);
        check("len0 busy", out_busy, 1'b0);
        tick();
        check("len0 done pulse", out_done, 1'b0);
        check("len0 busy after", out_busy, 1'b0);
        repeat (20) tick();
        check("len0 scl edges", n_scl_e - s_scl, 0);
        check("len0 sda edges", n_sda_e - s_sda, 0);
        check("len0 done count", n_done - s_done, 1);

        // reset during RDATA, then a clean read straight after
        snap();
        launch(16'h0012, 8'd1);
        for (int i = 0; i < 3000 && m_mode != M_TX; i++) tick();
        check("rst reached rdata", m_mode, M_TX);
        repeat (10) tick();
        slv_en = 1'b0;
        in_rst = 1'b1;
        #1;
        check("midrst scl", out_scl, 1'b1);
        check("midrst sda", sda_bus, 1'b1);
        check("midrst busy", out_busy, 1'b0);
        check("midrst data", out_data, 8'h00);
        tick();
        in_rst = 1'b0;
        slv_en = 1'b1;
        check("midrst no done", n_done - s_done, 0);
        check("midrst no valid", n_valid - s_val, 0);
        s_rx = rx_log.size(); s_start = n_start; s_stop = n_stop; s_mack = mack_log.size();
        launch(16'h0012, 8'd1);
        check("post busy", out_busy, 1'b1);
        wait_done("post", 3000);
        check("post nack", out_nack, 1'b0);
        check_frame("post", 8'h00, 8'h12);
        check("post valid count", n_valid - s_val, 1);
        check("post data", val_at(s_vlog), 8'hA5);
        check("post mack nack", mack_at(s_mack), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
